// File: rtl/id_hazard_fwd_unit_if.sv
// ID-stage hazard/forwarding bundle: pipeline-side signals plus FSM debug view.
// Optional HAZARD_STALL_COUNT_EN adds the o_stall_cycles counter output.
interface id_hazard_fwd_unit_if #(
    parameter int NB_ADDR = 5,
    parameter int NB_CNT  = 2
);
    logic               i_pipe_en;
    logic [NB_ADDR-1:0] i_rs_id;
    logic [NB_ADDR-1:0] i_rt_id;
    logic               i_use_rs_id;
    logic               i_use_rt_id;
    logic               i_branch_id;
    logic               i_branch_taken_id;
    logic [NB_ADDR-1:0] i_rd_ex;
    logic               i_regWrite_ex;
    logic               i_memRead_ex;
    logic [NB_ADDR-1:0] i_rd_ex_m;
    logic               i_regWrite_ex_m;
    logic               i_memRead_ex_m;
    logic [NB_ADDR-1:0] i_rd_m_wb;
    logic               i_regWrite_m_wb;
    logic [1:0]         o_forwardA_ID;
    logic [1:0]         o_forwardB_ID;
    logic               o_stall;
    logic               o_flush_if;
    // Debug view of the stall FSM: 0 = S_IDLE, 1 = S_STALL.
    logic               o_dbg_state;
    logic [NB_CNT-1:0]  o_dbg_cnt;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0]        o_stall_cycles;
`endif

    modport master (
        output i_pipe_en, i_rs_id, i_rt_id, i_use_rs_id, i_use_rt_id,
        output i_branch_id, i_branch_taken_id,
        output i_rd_ex, i_regWrite_ex, i_memRead_ex,
        output i_rd_ex_m, i_regWrite_ex_m, i_memRead_ex_m,
        output i_rd_m_wb, i_regWrite_m_wb,
        input  o_forwardA_ID, o_forwardB_ID, o_stall, o_flush_if,
`ifdef HAZARD_STALL_COUNT_EN
        input  o_stall_cycles,
`endif
        input  o_dbg_state, o_dbg_cnt
    );

    modport slave (
        input  i_pipe_en, i_rs_id, i_rt_id, i_use_rs_id, i_use_rt_id,
        input  i_branch_id, i_branch_taken_id,
        input  i_rd_ex, i_regWrite_ex, i_memRead_ex,
        input  i_rd_ex_m, i_regWrite_ex_m, i_memRead_ex_m,
        input  i_rd_m_wb, i_regWrite_m_wb,
        output o_forwardA_ID, o_forwardB_ID, o_stall, o_flush_if,
`ifdef HAZARD_STALL_COUNT_EN
        output o_stall_cycles,
`endif
        output o_dbg_state, o_dbg_cnt
    );
endinterface

// File: rtl/id_hazard_fwd_unit.sv
// ID-stage forwarding selects, load-use/branch stall detection, IF/ID flush.
// Optional HAZARD_STALL_COUNT_EN adds a saturating stalled-cycle counter.
module id_hazard_fwd_unit #(
    parameter int NB_ADDR = 5,
    parameter int NB_CNT  = 2
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    id_hazard_fwd_unit_if.slave bus
);
    localparam logic [NB_ADDR-1:0] R_ZERO = '0;

    typedef enum logic {S_IDLE = 1'b0, S_STALL = 1'b1} state_t;

    state_t            r_state;
    logic [NB_CNT-1:0] r_cnt;

    function automatic logic f_match(input logic [NB_ADDR-1:0] x,
                                     input logic [NB_ADDR-1:0] rd,
                                     input logic we);
        return we && (rd != R_ZERO) && (rd == x);
    endfunction

    function automatic logic [NB_CNT-1:0] f_need(input logic m_ex, input logic m_exm,
                                                 input logic ld_ex, input logic ld_exm,
                                                 input logic br);
        logic [NB_CNT-1:0] n;
        n = '0;
        if (m_ex && ld_ex)
            n = br ? NB_CNT'(2) : NB_CNT'(1);
        else if (m_ex && br)
            n = NB_CNT'(1);
        else if (m_exm && ld_exm && br)
            n = NB_CNT'(1);
        return n;
    endfunction

    logic w_rs_ex, w_rs_exm, w_rs_wb, w_rt_ex, w_rt_exm, w_rt_wb;
    assign w_rs_ex  = bus.i_use_rs_id && f_match(bus.i_rs_id, bus.i_rd_ex,   bus.i_regWrite_ex);
    assign w_rs_exm = bus.i_use_rs_id && f_match(bus.i_rs_id, bus.i_rd_ex_m, bus.i_regWrite_ex_m);
    assign w_rs_wb  = bus.i_use_rs_id && f_match(bus.i_rs_id, bus.i_rd_m_wb, bus.i_regWrite_m_wb);
    assign w_rt_ex  = bus.i_use_rt_id && f_match(bus.i_rt_id, bus.i_rd_ex,   bus.i_regWrite_ex);
    assign w_rt_exm = bus.i_use_rt_id && f_match(bus.i_rt_id, bus.i_rd_ex_m, bus.i_regWrite_ex_m);
    assign w_rt_wb  = bus.i_use_rt_id && f_match(bus.i_rt_id, bus.i_rd_m_wb, bus.i_regWrite_m_wb);

    // A load in EX/MEM has no data yet, so it cannot be a forwarding source.
    logic [1:0] w_fwd_a, w_fwd_b;
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        if (w_rs_exm && !bus.i_memRead_ex_m) w_fwd_a = 2'b01;
        else if (w_rs_wb)                    w_fwd_a = 2'b10;
        if (w_rt_exm && !bus.i_memRead_ex_m) w_fwd_b = 2'b01;
        else if (w_rt_wb)                    w_fwd_b = 2'b10;
    end

    logic [NB_CNT-1:0] w_n_rs, w_n_rt, w_n;
    assign w_n_rs = f_need(w_rs_ex, w_rs_exm, bus.i_memRead_ex, bus.i_memRead_ex_m, bus.i_branch_id);
    assign w_n_rt = f_need(w_rt_ex, w_rt_exm, bus.i_memRead_ex, bus.i_memRead_ex_m, bus.i_branch_id);
    assign w_n    = (w_n_rs > w_n_rt) ? w_n_rs : w_n_rt;

    logic w_stall_raw;
    assign w_stall_raw = (r_state == S_STALL) || (w_n != '0);

    // Only stalls longer than one cycle are committed; the first cycle is combinational.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (bus.i_pipe_en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_n >= NB_CNT'(2)) begin
                        r_cnt   <= w_n - NB_CNT'(1);
                        r_state <= S_STALL;
                    end
                end
                S_STALL: begin
                    r_cnt <= r_cnt - NB_CNT'(1);
                    if (r_cnt == NB_CNT'(1)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_forwardA_ID = i_rst_n ? w_fwd_a : 2'b00;
    assign bus.o_forwardB_ID = i_rst_n ? w_fwd_b : 2'b00;
    assign bus.o_stall       = i_rst_n && w_stall_raw;
    assign bus.o_flush_if    = i_rst_n && bus.i_branch_taken_id && !w_stall_raw;
    assign bus.o_dbg_state   = (r_state == S_STALL);
    assign bus.o_dbg_cnt     = r_cnt;

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] r_stall_cycles;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_stall_cycles <= '0;
        else if (w_stall_raw && bus.i_pipe_en && (r_stall_cycles != 32'hFFFF_FFFF))
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end
    assign bus.o_stall_cycles = i_rst_n ? r_stall_cycles : 32'd0;
`endif
endmodule

// File: tb/tb_id_hazard_fwd_unit.sv
// Directed bench for id_hazard_fwd_unit: per-cycle expectations into a queue,
// checked by an independent negedge monitor.
module tb_id_hazard_fwd_unit;
`ifdef HAZARD_STALL_COUNT_EN
    localparam int W = 9 + 32;
`else
    localparam int W = 9;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic [31:0]  exp_sc = 32'd0;

    id_hazard_fwd_unit_if #(.NB_ADDR(5), .NB_CNT(2)) bus ();

    id_hazard_fwd_unit #(.NB_ADDR(5), .NB_CNT(2)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    // clock / reset
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic clr();
        bus.i_pipe_en = 1'b1;
        bus.i_rs_id = '0; bus.i_rt_id = '0;
        bus.i_use_rs_id = 1'b0; bus.i_use_rt_id = 1'b0;
        bus.i_branch_id = 1'b0; bus.i_branch_taken_id = 1'b0;
        bus.i_rd_ex = '0;   bus.i_regWrite_ex = 1'b0;   bus.i_memRead_ex = 1'b0;
        bus.i_rd_ex_m = '0; bus.i_regWrite_ex_m = 1'b0; bus.i_memRead_ex_m = 1'b0;
        bus.i_rd_m_wb = '0; bus.i_regWrite_m_wb = 1'b0;
    endtask

    task automatic chk(input string name, input logic [1:0] fa, input logic [1:0] fb,
                       input logic st, input logic fl, input logic ds, input logic [1:0] dc);
        logic [W-1:0] e;
`ifdef HAZARD_STALL_COUNT_EN
        e = {fa, fb, st, fl, ds, dc, (i_rst_n ? exp_sc : 32'd0)};
        if (!i_rst_n) exp_sc = 32'd0;
        else if (st && bus.i_pipe_en) exp_sc = exp_sc + 32'd1;
`else
        e = {fa, fb, st, fl, ds, dc};
`endif
        exp_q.push_back(e);
        name_q.push_back(name);
        @(posedge i_clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge i_clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e, a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
`ifdef HAZARD_STALL_COUNT_EN
            a = {bus.o_forwardA_ID, bus.o_forwardB_ID, bus.o_stall, bus.o_flush_if,
                 bus.o_dbg_state, bus.o_dbg_cnt, bus.o_stall_cycles};
`else
            a = {bus.o_forwardA_ID, bus.o_forwardB_ID, bus.o_stall, bus.o_flush_if,
                 bus.o_dbg_state, bus.o_dbg_cnt};
`endif
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h {fwdA,fwdB,stall,flush,state,cnt[,cycles]}",
                         n, a, e);
            end
        end
    end

    initial begin
        clr();
        repeat (2) @(posedge i_clk);
        #1;
        // outputs forced low while in reset, even with a live forwarding match
        bus.i_rs_id = 5'd3; bus.i_use_rs_id = 1'b1;
        bus.i_rd_ex_m = 5'd3; bus.i_regWrite_ex_m = 1'b1; bus.i_branch_taken_id = 1'b1;
        chk("reset_forced", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
        i_rst_n = 1'b1;

        // forwarding priority
        clr();
        bus.i_rs_id = 5'd3; bus.i_use_rs_id = 1'b1;
        bus.i_rd_ex_m = 5'd3; bus.i_regWrite_ex_m = 1'b1;
        bus.i_rd_m_wb = 5'd3; bus.i_regWrite_m_wb = 1'b1;
        chk("fwd_exm_prio", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.i_regWrite_ex_m = 1'b0;
        chk("fwd_wb", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.i_rs_id = 5'd0; bus.i_rd_ex_m = 5'd0; bus.i_regWrite_ex_m = 1'b1; bus.i_rd_m_wb = 5'd0;
        chk("fwd_r0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.i_rs_id = 5'd3; bus.i_rd_ex_m = 5'd3; bus.i_memRead_ex_m = 1'b1; bus.i_rd_m_wb = 5'd3;
        chk("fwd_skip_exm_load", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.i_use_rs_id = 1'b0;
        chk("fwd_use_gate", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);

        // load-use, non-branch
        clr();
        bus.i_rt_id = 5'd5; bus.i_use_rt_id = 1'b1;
        bus.i_rd_ex = 5'd5; bus.i_regWrite_ex = 1'b1; bus.i_memRead_ex = 1'b1;
        chk("loaduse_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.i_rd_ex = 5'd0; bus.i_regWrite_ex = 1'b0; bus.i_memRead_ex = 1'b0;
        bus.i_rd_ex_m = 5'd5; bus.i_regWrite_ex_m = 1'b1; bus.i_memRead_ex_m = 1'b1;
        chk("loaduse_exm_nostall", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.i_rd_ex_m = 5'd0; bus.i_regWrite_ex_m = 1'b0; bus.i_memRead_ex_m = 1'b0;
        bus.i_rd_m_wb = 5'd5; bus.i_regWrite_m_wb = 1'b1;
        chk("loaduse_wb_fwd", 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0);

        // branch after load: committed two-cycle stall
        clr();
        bus.i_branch_id = 1'b1; bus.i_rs_id = 5'd7; bus.i_use_rs_id = 1'b1;
        bus.i_rd_ex = 5'd7; bus.i_regWrite_ex = 1'b1; bus.i_memRead_ex = 1'b1;
        chk("brload_c1", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);
        clr();
        chk("brload_c2_committed", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'd1);
        chk("brload_c3_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);

        // branch after ALU op, then branch after load in EX/MEM
        clr();
        bus.i_branch_id = 1'b1; bus.i_rt_id = 5'd4; bus.i_use_rt_id = 1'b1;
        bus.i_rd_ex = 5'd4; bus.i_regWrite_ex = 1'b1;
        chk("bralu_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.i_rd_ex = 5'd0; bus.i_regWrite_ex = 1'b0;
        bus.i_rd_ex_m = 5'd4; bus.i_regWrite_ex_m = 1'b1;
        chk("bralu_fwd_exm", 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 2'd0);
        clr();
        bus.i_branch_id = 1'b1; bus.i_rs_id = 5'd6; bus.i_use_rs_id = 1'b1;
        bus.i_rd_ex_m = 5'd6; bus.i_regWrite_ex_m = 1'b1; bus.i_memRead_ex_m = 1'b1;
        chk("br_exm_load_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);

        // flush vs stall
        clr();
        bus.i_branch_id = 1'b1; bus.i_branch_taken_id = 1'b1;
        chk("flush_plain", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0);
        bus.i_rs_id = 5'd7; bus.i_use_rs_id = 1'b1;
        bus.i_rd_ex = 5'd7; bus.i_regWrite_ex = 1'b1; bus.i_memRead_ex = 1'b1;
        chk("flush_held_c1", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);
        chk("flush_held_c2", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'd1);
        bus.i_rd_ex = 5'd0; bus.i_regWrite_ex = 1'b0; bus.i_memRead_ex = 1'b0;
        bus.i_rd_m_wb = 5'd7; bus.i_regWrite_m_wb = 1'b1;
        chk("flush_release", 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 2'd0);

        // freeze and reset mid-stall
        clr();
        bus.i_branch_id = 1'b1; bus.i_rs_id = 5'd7; bus.i_use_rs_id = 1'b1;
        bus.i_rd_ex = 5'd7; bus.i_regWrite_ex = 1'b1; bus.i_memRead_ex = 1'b1;
        bus.i_pipe_en = 1'b0;
        chk("freeze_idle", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.i_pipe_en = 1'b1;
        chk("enter_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0);
        clr();
        bus.i_pipe_en = 1'b0;
        for (int i = 0; i < 3; i++)
            chk("freeze_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'd1);
        i_rst_n = 1'b0;
        bus.i_branch_taken_id = 1'b1; bus.i_rs_id = 5'd3; bus.i_use_rs_id = 1'b1;
        bus.i_rd_ex_m = 5'd3; bus.i_regWrite_ex_m = 1'b1;
        chk("reset_mid_stall", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'd1);
        i_rst_n = 1'b1;
        clr();
        chk("after_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0);

        // final report
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge i_clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_hazard_fwd_unit.md
Name: id_hazard_fwd_unit

Overview:
Parametrised ID-stage hazard and forwarding unit for the 5-stage MIPS pipeline. It generalises ID-stage forwarding to two sources, EX/MEM and MEM/WB, with 2-bit priority selects per operand. It adds load-use and branch-operand stall detection. A small FSM commits multi-cycle stalls. It also generates the IF/ID flush for taken branches. It sits beside the ID stage, between the pipeline registers and the PC/IF-ID write enables.

Parameters:
NB_ADDR, 5, register address width
NB_CNT, 2, stall counter width; must hold the maximum stall length (2)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_pipe_en  in  1  pipeline advance enable (debug step); low freezes FSM/counter
i_rs_id  in  NB_ADDR  rs address in ID
i_rt_id  in  NB_ADDR  rt address in ID
i_use_rs_id  in  1  ID instruction reads rs
i_use_rt_id  in  1  ID instruction reads rt
i_branch_id  in  1  ID instruction is a branch/jr (operands consumed in ID)
i_branch_taken_id  in  1  branch/jump resolved taken in ID
i_rd_ex  in  NB_ADDR  destination in ID/EX
i_regWrite_ex  in  1  ID/EX writes register
i_memRead_ex  in  1  ID/EX is a load
i_rd_ex_m  in  NB_ADDR  destination in EX/MEM
i_regWrite_ex_m  in  1  EX/MEM writes register
i_memRead_ex_m  in  1  EX/MEM is a load
i_rd_m_wb  in  NB_ADDR  destination in MEM/WB
i_regWrite_m_wb  in  1  MEM/WB writes register
o_forwardA_ID  out  2  rs select: 00 regfile, 01 EX/MEM, 10 MEM/WB
o_forwardB_ID  out  2  rt select, same encoding
o_stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
o_flush_if  out  1  zero IF/ID (squash fetched instruction)

Behaviour:
- Define match(x, rd, we) = we && (rd != 0) && (rd == x), gated by i_use_rs_id or i_use_rt_id respectively.
- Forwarding (combinational), per operand:
  - 01 if the EX/MEM destination matches and i_memRead_ex_m = 0.
  - Else 10 if the MEM/WB destination matches.
  - Else 00.
  - EX/MEM has priority. Register 0 is never forwarded.
- Required stall length N (combinational), taken as the maximum over rs and rt:
  - Load in ID/EX matching: N=2 if i_branch_id, else N=1.
  - ALU op in ID/EX matching with i_branch_id: N=1.
  - Load in EX/MEM matching with i_branch_id: N=1.
  - Otherwise N=0.
- FSM states S_IDLE and S_STALL, with counter cnt[NB_CNT-1:0].
- S_IDLE:
  - o_stall = (N != 0), combinational in the same cycle as detection.
  - If N >= 2 and i_pipe_en: cnt <= N-1, go to S_STALL.
  - Otherwise remain in S_IDLE. Hazard inputs are re-evaluated every cycle.
- S_STALL:
  - o_stall = 1 regardless of hazard inputs (the committed stall).
  - If i_pipe_en: cnt <= cnt-1; go to S_IDLE when cnt == 1.
- i_pipe_en low: state and cnt hold; o_stall still reflects the current state/N.
- o_flush_if = i_branch_taken_id && !o_stall. A branch whose operands are not ready never flushes.
- Simultaneous stall and taken branch: stall wins; the flush occurs on the first non-stalled cycle.
- Reset (i_rst_n low at a clock edge): state S_IDLE, cnt 0.
- While i_rst_n is low, all outputs are forced low: forwards 00, o_stall 0, o_flush_if 0.
- Reset mid-stall aborts the stall immediately.
- No registered latency on the forwarding selects. The FSM adds zero latency to the first stall cycle.

Optional Feature:
- Macro HAZARD_STALL_COUNT_EN.
- When defined: adds output o_stall_cycles [31:0].
  - Increments on every cycle with o_stall=1 and i_pipe_en=1.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- 1. Forwarding priority: rs=3, rd_ex_m=3/regWrite_ex_m=1, rd_m_wb=3/regWrite_m_wb=1, use_rs=1 -> forwardA=01. Drop regWrite_ex_m -> 10. Set rs=0 with both writers at rd=0 -> 00.
- 2. Load-use, non-branch: rt=5, rd_ex=5, memRead_ex=1, regWrite_ex=1, use_rt=1 -> o_stall=1 for exactly 1 cycle.
  - Next cycle (load moved to EX/MEM, no longer a hazard for a non-branch) -> o_stall=0.
  - Then forwardB=10 once the load reaches MEM/WB.
- 3. Branch after load: branch_id=1, rs=7 matches a load in ID/EX -> o_stall=1 for 2 consecutive cycles (S_IDLE, then S_STALL with cnt=1) even if the hazard inputs are cleared in cycle 2. Third cycle: S_IDLE, o_stall=0.
- 4. Branch after ALU op: branch_id=1, rt=4 = rd_ex, regWrite_ex=1, memRead_ex=0 -> 1 stall cycle. Next cycle, rd_ex_m=4 -> forwardB=01, o_stall=0.
- 5. Flush/stall interaction: branch_taken_id=1 during a stall -> o_flush_if=0. On the first cycle with o_stall=0 -> o_flush_if=1.
- 6. Freeze and reset: enter S_STALL, drop i_pipe_en for 3 cycles -> cnt holds and o_stall stays 1. Then assert i_rst_n=0 for 1 cycle -> all outputs 0, state S_IDLE. With HAZARD_STALL_COUNT_EN defined, o_stall_cycles=0 after reset.
